set_job_dispatcher: RTL

Host-side initiator for the circle-set counting engine: accepts counting jobs (three circle centres, three radii, mode) from an upstream producer into a small FIFO. Issues them one at a time over the engine's en/busy/valid handshake, holding the job operands stable for the whole scan. Captures the returned candidate count and presents it downstream with the job tag. A watchdog turns a hung engine into an error result instead of a deadlock.

---
 rtl/set_pkg.sv | 34 +++
 rtl/set_job_fifo.sv | 70 +++++++
 rtl/set_job_dispatcher.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/set_pkg.sv
// Shared types and widths for the circle-set job dispatcher.
package set_pkg;

    localparam int COORD_W   = 4;
    localparam int CNT_W     = 8;
    localparam int CENTRAL_W = 6 * COORD_W;   // {x1,y1,x2,y2,x3,y3}
    localparam int RADIUS_W  = 3 * COORD_W;   // {r1,r2,r3}

    // Region selector understood by the counting engine; forwarded untouched.
    typedef enum logic [1:0] {
        MODE_C1  = 2'b00,   // inside C1
        MODE_AND = 2'b01,   // inside C1 and C2
        MODE_XOR = 2'b10,   // inside exactly one of C1, C2
        MODE_TWO = 2'b11    // inside exactly two of C1..C3
    } mode_e;

    // Operands of one counting job; the user tag travels beside it because
    // its width is a parameter of the dispatcher.
    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        mode_e                mode;
    } job_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_RESULT,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/set_job_fifo.sv
// Synchronous FIFO holding pending jobs; push and pop may share a cycle.
module set_job_fifo
    import set_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Occupancy flags and next pointer/count values.
    // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
    always_comb begin
        full     = (count_q == CNT_FULL);
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    assign rdata = mem_q[rd_ptr_q];

    // Pointer and occupancy registers.
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/set_job_dispatcher.sv
// Queues counting jobs and drives them one at a time into the circle-set
// engine, returning each count (or a watchdog error) with its tag.
module set_job_dispatcher
    import set_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [CENTRAL_W-1:0] job_central,
    input  logic [RADIUS_W-1:0]  job_radius,
    input  logic [1:0]           job_mode,
    input  logic [TAG_W-1:0]     job_tag,
    output logic                 en,
    output logic [CENTRAL_W-1:0] central,
    output logic [RADIUS_W-1:0]  radius,
    output logic [1:0]           mode,
    input  logic                 busy,
    input  logic                 valid,
    input  logic [CNT_W-1:0]     candidate,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CNT_W-1:0]     res_count,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 res_err,
    output logic [7:0]           jobs_done
);

    localparam int OP_W = $bits(job_op_t);
    localparam int FW   = TAG_W + OP_W;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [FW-1:0]    fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop;
    job_op_t          rd_op;
    logic [TAG_W-1:0] rd_tag;

    state_e           state_q, state_d;
    job_op_t          op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_err_q, res_err_d;
    logic [7:0]       jobs_done_q, jobs_done_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;

    assign fifo_wdata = {job_tag, job_central, job_radius, job_mode};
    assign rd_op      = job_op_t'(fifo_rdata[OP_W-1:0]);
    assign rd_tag     = fifo_rdata[FW-1 -: TAG_W];

    set_job_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (job_valid),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready depends on current occupancy only, so a full FIFO refuses a job
    // even in the cycle it is being popped.
    assign job_ready = !fifo_full;

    // Operands come straight from the job register, which only changes on a
    // pop in IDLE, so the engine sees stable values for the whole scan.
    assign central   = op_q.central;
    assign radius    = op_q.radius;
    assign mode      = op_q.mode;
    assign res_count = res_count_q;
    assign res_tag   = res_tag_q;
    assign res_err   = res_err_q;
    assign jobs_done = jobs_done_q;

    // Job sequencing: issue, wait for the engine or the watchdog, hand off
    // the result, then let the engine finish before the next job.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tag_d       = tag_q;
        res_count_d = res_count_q;
        res_tag_d   = res_tag_q;
        res_err_d   = res_err_q;
        jobs_done_d = jobs_done_q;
        wdog_d      = wdog_q;
        fifo_pop    = 1'b0;
        en          = 1'b0;
        res_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !busy) begin
                    fifo_pop = 1'b1;
                    op_d     = rd_op;
                    tag_d    = rd_tag;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                en      = 1'b1;
                wdog_d  = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_RUN: begin
                wdog_d = wdog_q + WD_W'(1);
                // A real result wins over a watchdog expiring in the same cycle.
                if (valid) begin
                    res_count_d = candidate;
                    res_err_d   = 1'b0;
                    res_tag_d   = tag_q;
                    state_d     = ST_RESULT;
                end else if (wdog_q == WD_LAST) begin
                    res_count_d = '0;
                    res_err_d   = 1'b1;
                    res_tag_d   = tag_q;
                    state_d     = ST_RESULT;
                end else if (state_q == ST_WAIT_BUSY && busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    jobs_done_d = jobs_done_q + 8'd1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A timed-out engine may still be scanning; wait it out.
                if (!busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer, operand, result and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            tag_q       <= '0;
            res_count_q <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
            jobs_done_q <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            res_count_q <= res_count_d;
            res_tag_q   <= res_tag_d;
            res_err_q   <= res_err_d;
            jobs_done_q <= jobs_done_d;
            wdog_q      <= wdog_d;
        end
    end

endmodule
